// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer
// Initiator-side controller for the dice roller. Accepts a "roll N dice of
// type X" request, issues one roll pulse per die, maps each raw 8-bit result
// to a face value 1..sides and accumulates the running sum.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         request strobe, sampled in IDLE only
//   num_dice      dice count for the request (0..15)
//   die_type      00=d4, 01=d6, 10=d8, 11=d20
//   roll          one-cycle roll pulse to the roller
//   die_select    die type to the roller, stable for the whole request
//   roll_done     roller result strobe, qualifies rolled_number
//   rolled_number raw roller result
//   busy          high from accepted start until DONE exits
//   done          one-cycle completion pulse
//   error         timeout flag, valid with done, held until next start
//   sum           accumulated total (max 300)
//   last_face     most recent mapped face value (1..20)
//
// state | meaning
// IDLE  | waiting for start
// REQ   | roll pulse out, timeout counter loaded
// WAIT  | waiting for roll_done or timeout
// DONE  | emit done, drop busy, return to IDLE

module dice_roll_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] num_dice,
  input  logic [1:0] die_type,
  output logic       roll,
  output logic [1:0] die_select,
  input  logic       roll_done,
  input  logic [7:0] rolled_number,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] sum,
  output logic [4:0] last_face
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT_CYCLES);

  state_t     state;
  logic [3:0] remaining;
  logic [7:0] timer;
  logic [4:0] face;

  // Powers of two reduce to a mask; d6 and d20 use a constant-divisor modulo.
  function automatic logic [4:0] face_of(input logic [7:0] raw, input logic [1:0] kind);
    logic [4:0] m;
    case (kind)
      2'b00:   m = 5'(raw & 8'd3);
      2'b01:   m = 5'(raw % 8'd6);
      2'b10:   m = 5'(raw & 8'd7);
      default: m = 5'(raw % 8'd20);
    endcase
    return m + 5'd1;
  endfunction

  assign face = face_of(rolled_number, die_select);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      roll       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      sum        <= 9'd0;
      last_face  <= 5'd0;
      die_select <= 2'b00;
      remaining  <= 4'd0;
      timer      <= 8'd0;
    end else begin
      roll <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            error <= 1'b0;
            sum   <= 9'd0;
            if (num_dice != 4'd0) begin
              remaining  <= num_dice;
              die_select <= die_type;
              last_face  <= 5'd0;
              roll       <= 1'b1;  // roll is high for the whole REQ cycle
              state      <= REQ;
            end else begin
              state <= DONE;
            end
          end
        end
        REQ: begin
          timer <= TIMER_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (roll_done) begin
            last_face <= face;
            sum       <= sum + {4'd0, face};
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              state <= DONE;
            end else begin
              roll  <= 1'b1;
              state <= REQ;
            end
          end else begin
            timer <= timer - 8'd1;
            if (timer == 8'd1) begin
              error <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_sequencer.sv
module tb_dice_roll_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset, start, roll, roll_done, busy, done, error;
  logic [3:0] num_dice;
  logic [1:0] die_type, die_select;
  logic [7:0] rolled_number;
  logic [8:0] sum;
  logic [4:0] last_face;

  dice_roll_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_dice(num_dice),
    .die_type(die_type), .roll(roll), .die_select(die_select),
    .roll_done(roll_done), .rolled_number(rolled_number), .busy(busy),
    .done(done), .error(error), .sum(sum), .last_face(last_face)
  );

  always #5 clk = ~clk;

  typedef struct {int sum; int face; int err; int rolls; int lat;} exp_t;
  typedef struct {bit resp; bit early; logic [7:0] val;} raw_t;

  exp_t exp_q[$];
  raw_t raw_q[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, roll_total = 0, done_seen = 0;
  int start_cyc = 0, start_rolls = 0;
  int stray_req = 0;
  logic [1:0] cur_type = 2'b00;
  int m_sum = 0, m_face = 0, m_rolls = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int face_model(input logic [7:0] v, input logic [1:0] t);
    int s;
    case (t)
      2'b00:   s = 4;
      2'b01:   s = 6;
      2'b10:   s = 8;
      default: s = 20;
    endcase
    return int'(v) % s + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Roller model: answers one cycle after each roll pulse unless told not to.
  initial begin
    bit         pend = 0;
    logic [7:0] pend_val = 8'h00;
    int         stray_ack = 0;
    raw_t       r;
    roll_done = 1'b0;
    rolled_number = 8'h00;
    forever begin
      @(negedge clk);
      roll_done = 1'b0;
      if (pend) begin
        roll_done = 1'b1;
        rolled_number = pend_val;
        pend = 0;
      end
      if (stray_req != stray_ack) begin
        roll_done = 1'b1;
        rolled_number = 8'h13;
        stray_ack = stray_req;
      end
      if (roll === 1'b1 && raw_q.size() > 0) begin
        r = raw_q.pop_front();
        if (r.early) begin
          roll_done = 1'b1;
          rolled_number = 8'hFF;
        end
        if (r.resp) begin
          pend = 1;
          pend_val = r.val;
        end
      end
    end
  end

  // Monitor / scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (roll === 1'b1) begin
        roll_total++;
        check_eq("die_select", int'(die_select), int'(cur_type));
      end
      if (done === 1'b1) begin
        done_seen++;
        check_eq("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("sum", int'(sum), e.sum);
          check_eq("last_face", int'(last_face), e.face);
          check_eq("error", int'(error), e.err);
          check_eq("roll_count", roll_total - start_rolls, e.rolls);
          check_eq("done_latency", cyc - start_cyc, e.lat);
          check_eq("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic new_req(input int n);
    m_sum = 0;
    m_rolls = 0;
    if (n != 0) m_face = 0;
  endtask

  task automatic add_die(input logic [1:0] t, input logic [7:0] v, input bit resp, input bit early);
    raw_t r;
    r.resp = resp; r.early = early; r.val = v;
    raw_q.push_back(r);
    m_rolls++;
    if (resp) begin
      m_face = face_model(v, t);
      m_sum += m_face;
    end
  endtask

  task automatic do_req(input int n, input logic [1:0] t, input int lat, input int inject, input int err);
    int d0;
    exp_t e;
    @(posedge clk); #1;
    e.sum = m_sum; e.face = m_face; e.err = err; e.rolls = m_rolls; e.lat = lat;
    exp_q.push_back(e);
    start_rolls = roll_total;
    start_cyc = cyc;
    cur_type = t;
    d0 = done_seen;
    start = 1'b1;
    num_dice = 4'(n);
    die_type = t;
    for (int i = 1; i < 300 && done_seen == d0; i++) begin
      @(posedge clk); #1;
      start = (i == inject);
      num_dice = ~4'(n);
      die_type = ~t;
    end
    start = 1'b0;
    check_eq("done_seen", done_seen - d0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, d0;
    reset = 1'b1; start = 1'b0; num_dice = 4'd0; die_type = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_roll", int'(roll), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_error", int'(error), 0);
    check_eq("rst_sum", int'(sum), 0);
    check_eq("rst_face", int'(last_face), 0);
    check_eq("rst_sel", int'(die_select), 0);
    reset = 1'b0;

    // 3d6 with a start pulsed mid-request (ignored)
    new_req(3);
    add_die(2'b01, 8'h05, 1, 0);
    add_die(2'b01, 8'h0C, 1, 0);
    add_die(2'b01, 8'hFF, 1, 0);
    do_req(3, 2'b01, 8, 3, 0);
    check_eq("sum_3d6", int'(sum), 11);

    // d20 boundaries
    new_req(1); add_die(2'b11, 8'h13, 1, 0); do_req(1, 2'b11, 4, 0, 0);
    check_eq("face_d20_top", int'(last_face), 20);
    new_req(1); add_die(2'b11, 8'h14, 1, 0); do_req(1, 2'b11, 4, 0, 0);
    check_eq("sum_d20_wrap", int'(sum), 1);

    // stray roll_done in IDLE is ignored
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    check_eq("stray_sum", int'(sum), m_sum);
    check_eq("stray_face", int'(last_face), m_face);

    // 15d20 max sum
    new_req(15);
    for (int i = 0; i < 15; i++) add_die(2'b11, 8'h13, 1, 0);
    do_req(15, 2'b11, 32, 0, 0);
    check_eq("max_sum", int'(sum), 300);

    // strobe coincident with roll in REQ is ignored
    new_req(2);
    add_die(2'b01, 8'h00, 1, 1);
    add_die(2'b01, 8'h0B, 1, 0);
    do_req(2, 2'b01, 6, 0, 0);

    // timeout: 2d8, second die never answers
    new_req(2);
    add_die(2'b10, 8'h07, 1, 0);
    add_die(2'b10, 8'h00, 0, 0);
    do_req(2, 2'b10, 2 * 1 + 3 + TO, 0, 1);
    check_eq("timeout_sum", int'(sum), 8);

    // zero dice: no roll, done two cycles after start, sum cleared
    new_req(0);
    do_req(0, 2'b00, 2, 0, 0);

    // reset during WAIT of 4d4 after two results
    new_req(4);
    add_die(2'b00, 8'h01, 1, 0);
    add_die(2'b00, 8'h02, 1, 0);
    add_die(2'b00, 8'h00, 0, 0);
    @(posedge clk); #1;
    base = roll_total;
    cur_type = 2'b00;
    start = 1'b1; num_dice = 4'd4; die_type = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && roll_total - base < 3; i++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_mid_rolls", roll_total - base, 3);
    repeat (3) @(posedge clk);
    #1;
    d0 = done_seen;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_sum", int'(sum), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_face", int'(last_face), 0);
    check_eq("mid_rst_sel", int'(die_select), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_rst_no_done", done_seen - d0, 0);
    new_req(1); add_die(2'b00, 8'h02, 1, 0); do_req(1, 2'b00, 4, 0, 0);
    check_eq("post_rst_sum", int'(sum), 3);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
